// File: rtl/id_operand_stage.sv
// Decode-operand stage: forwarding mux, load-use hazard detection and the ID/EX register.
// Define ID_STALL_CNT_EN to enable the saturating hazard-stall cycle counter.
module id_operand_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned FWD_SRCS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [REG_AW-1:0]            in_rs_addr_i,
    input  logic [REG_AW-1:0]            in_rt_addr_i,
    input  logic                         in_rs_read_i,
    input  logic                         in_rt_read_i,
    input  logic [DATA_W-1:0]            in_imm_i,
    input  logic [REG_AW-1:0]            in_wd_i,
    input  logic                         in_wreg_i,
    input  logic [1:0]                   in_cond_i,
    input  logic [7:0]                   in_aluop_i,
    input  logic [2:0]                   in_alusel_i,
    input  logic [DATA_W-1:0]            rf_rs_data_i,
    input  logic [DATA_W-1:0]            rf_rt_data_i,
    input  logic [FWD_SRCS-1:0]          fwd_wreg_i,
    input  logic [FWD_SRCS*REG_AW-1:0]   fwd_wd_i,
    input  logic [FWD_SRCS*DATA_W-1:0]   fwd_wdata_i,
    input  logic [FWD_SRCS-1:0]          fwd_rdy_i,
    input  logic                         flush_i,
    output logic                         stall_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_reg1_o,
    output logic [DATA_W-1:0]            out_reg2_o,
    output logic [REG_AW-1:0]            out_wd_o,
    output logic                         out_wreg_o,
    output logic [7:0]                   out_aluop_o,
    output logic [2:0]                   out_alusel_o,
    output logic [15:0]                  stall_cnt_o
);

    logic [REG_AW-1:0] op_addr [2];
    logic [DATA_W-1:0] op_rf   [2];
    logic [DATA_W-1:0] op_val  [2];
    logic [1:0]        op_read;
    logic [1:0]        op_haz;
    logic              hazard;
    logic              cond_ok;
    logic              accept;

    assign op_addr[0] = in_rs_addr_i;
    assign op_addr[1] = in_rt_addr_i;
    assign op_rf[0]   = rf_rs_data_i;
    assign op_rf[1]   = rf_rt_data_i;
    assign op_read    = {in_rt_read_i, in_rs_read_i};

    // Scan from lowest priority upward so the youngest matching source wins.
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            op_val[o] = op_rf[o];
            op_haz[o] = 1'b0;
            if (!op_read[o]) begin
                op_val[o] = in_imm_i;
            end else if (op_addr[o] == '0) begin
                op_val[o] = '0;
            end else begin
                for (int k = int'(FWD_SRCS) - 1; k >= 0; k--) begin
                    if (fwd_wreg_i[k] && fwd_wd_i[k*REG_AW +: REG_AW] == op_addr[o]) begin
                        op_val[o] = fwd_wdata_i[k*DATA_W +: DATA_W];
                        op_haz[o] = ~fwd_rdy_i[k];
                    end
                end
            end
        end
    end

    always_comb begin
        case (in_cond_i)
            2'b01:   cond_ok = (op_val[1] != '0);
            2'b10:   cond_ok = (op_val[1] == '0);
            default: cond_ok = 1'b1;
        endcase
    end

    assign hazard     = |op_haz;
    assign stall_o    = in_valid_i & hazard;
    assign in_ready_o = ~flush_i & ~hazard & (~out_valid_o | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o  <= 1'b0;
            out_reg1_o   <= '0;
            out_reg2_o   <= '0;
            out_wd_o     <= '0;
            out_wreg_o   <= 1'b0;
            out_aluop_o  <= 8'h00;
            out_alusel_o <= 3'b000;
        end else if (flush_i) begin
            out_valid_o  <= 1'b0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            out_reg1_o   <= op_val[0];
            out_reg2_o   <= op_val[1];
            out_wd_o     <= in_wd_i;
            out_wreg_o   <= in_wreg_i & cond_ok;
            out_aluop_o  <= in_aluop_i;
            out_alusel_o <= in_alusel_i;
        end else if (out_ready_i) begin
            out_valid_o  <= 1'b0;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_o && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
